// File: rtl/maze_player_mover.sv
// Player position tracker for the generated maze: turns direction pulses into wall-checked moves.
// Optional PLAYER_STEP_COUNT_EN adds a saturating committed-move counter output (step_count).
module maze_player_mover #(
    parameter int WIDTH    = 30,
    parameter int HEIGHT   = 40,
    parameter int READ_LAT = 2,
    parameter int START_X  = 0,
    parameter int START_Y  = 0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        gen_end,
    input  logic        move_up,
    input  logic        move_down,
    input  logic        move_left,
    input  logic        move_right,
    output logic [10:0] maze_address,
    input  logic        maze_address_data,
    output logic [5:0]  player_x,
    output logic [5:0]  player_y,
    output logic        busy,
    output logic        move_done,
    output logic        blocked,
`ifdef PLAYER_STEP_COUNT_EN
    output logic [15:0] step_count,
`endif
    output logic        at_exit
);

    typedef enum logic [1:0] {WAIT_GEN, READY, FETCH, DECIDE} state_t;

    localparam int          CW         = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
    localparam logic [10:0] START_ADDR = 11'(WIDTH * START_Y + START_X);

    state_t        state;
    logic [CW-1:0] cnt;
    logic [5:0]    tgt_x, tgt_y;

    logic          req_any, req_oob;
    logic [5:0]    req_x, req_y;

    function automatic logic [10:0] tile_addr(input logic [5:0] x, input logic [5:0] y);
        return 11'(WIDTH) * {5'd0, y} + {5'd0, x};
    endfunction

    // Fixed priority up > down > left > right; only the winner is bounds-checked.
    always_comb begin
        req_any = move_up | move_down | move_left | move_right;
        req_oob = 1'b0;
        req_x   = player_x;
        req_y   = player_y;
        if (move_up) begin
            req_oob = (player_y == 6'd0);
            req_y   = player_y - 6'd1;
        end else if (move_down) begin
            req_oob = ({1'b0, player_y} + 7'd1) >= 7'(HEIGHT);
            req_y   = player_y + 6'd1;
        end else if (move_left) begin
            req_oob = (player_x == 6'd0);
            req_x   = player_x - 6'd1;
        end else if (move_right) begin
            req_oob = ({1'b0, player_x} + 7'd1) >= 7'(WIDTH);
            req_x   = player_x + 6'd1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= WAIT_GEN;
            cnt          <= '0;
            tgt_x        <= 6'(START_X);
            tgt_y        <= 6'(START_Y);
            player_x     <= 6'(START_X);
            player_y     <= 6'(START_Y);
            maze_address <= START_ADDR;
            busy         <= 1'b0;
            move_done    <= 1'b0;
            blocked      <= 1'b0;
            at_exit      <= 1'b0;
`ifdef PLAYER_STEP_COUNT_EN
            step_count   <= 16'd0;
`endif
        end else if (!gen_end) begin
            // Maze being (re)generated: abandon any move and restart from the entry tile.
            state        <= WAIT_GEN;
            cnt          <= '0;
            tgt_x        <= 6'(START_X);
            tgt_y        <= 6'(START_Y);
            player_x     <= 6'(START_X);
            player_y     <= 6'(START_Y);
            maze_address <= START_ADDR;
            busy         <= 1'b0;
            move_done    <= 1'b0;
            blocked      <= 1'b0;
            at_exit      <= 1'b0;
`ifdef PLAYER_STEP_COUNT_EN
            step_count   <= 16'd0;
`endif
        end else begin
            move_done <= 1'b0;
            blocked   <= 1'b0;
            at_exit   <= (state != WAIT_GEN) && (player_y == 6'(HEIGHT - 1)) &&
                         (player_x >= 6'(WIDTH - 2));
            case (state)
                WAIT_GEN: state <= READY;
                READY: begin
                    if (req_any) begin
                        if (req_oob) begin
                            blocked <= 1'b1;
                        end else begin
                            tgt_x        <= req_x;
                            tgt_y        <= req_y;
                            maze_address <= tile_addr(req_x, req_y);
                            busy         <= 1'b1;
                            cnt          <= '0;
                            state        <= FETCH;
                        end
                    end
                end
                FETCH: begin
                    if (cnt == CW'(READ_LAT - 1)) state <= DECIDE;
                    else                          cnt   <= cnt + 1'b1;
                end
                DECIDE: begin
                    if (!maze_address_data) begin
                        player_x  <= tgt_x;
                        player_y  <= tgt_y;
                        move_done <= 1'b1;
`ifdef PLAYER_STEP_COUNT_EN
                        if (step_count != 16'hFFFF) step_count <= step_count + 16'd1;
`endif
                    end else begin
                        blocked      <= 1'b1;
                        maze_address <= tile_addr(player_x, player_y);
                    end
                    busy  <= 1'b0;
                    state <= READY;
                end
                default: state <= WAIT_GEN;
            endcase
        end
    end

endmodule
